// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring shift-subtract unsigned divider
//
// Computes dividend / divisor (ALU alu_b / alu_a), one quotient bit per
// clock, and hands the held result to the ALU with a one-cycle div_done
// pulse. A zero divisor skips the iteration loop and reports div_by_zero
// with an all-ones quotient and the dividend as remainder.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   request a division, sampled only in IDLE
//   dividend     in   WIDTH-bit dividend, captured on the accepting edge
//   divisor      in   WIDTH-bit divisor, captured on the accepting edge
//   busy         out  high while iterating
//   div_done     out  one-cycle pulse when results become valid
//   div_result   out  quotient, held until the next completion
//   div_rem      out  remainder, held with div_result
//   div_by_zero  out  divisor was zero, held with div_result

module div_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             div_done,
    output logic [WIDTH-1:0] div_result,
    output logic [WIDTH-1:0] div_rem,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] dvd_q;     // dividend, shifted left to expose the next MSB
    logic [WIDTH-1:0] dsr_q;     // captured divisor
    logic [WIDTH-1:0] prem_q;    // partial remainder
    logic [WIDTH-1:0] quo_q;     // quotient bits collected so far
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;

    // One restoring iteration. The shifted remainder needs WIDTH+1 bits:
    // with a divisor >= 2^(WIDTH-1) the shifted-out MSB is significant.
    logic [WIDTH:0]   prem_shift;
    logic [WIDTH:0]   prem_diff;
    logic             q_bit;
    logic [WIDTH-1:0] prem_d;
    logic [WIDTH-1:0] quo_d;

    always_comb begin
        prem_shift = {prem_q, dvd_q[WIDTH-1]};
        prem_diff  = prem_shift - {1'b0, dsr_q};
        // The partial remainder is always below the divisor, so the shifted
        // value is below twice the divisor: a successful subtract leaves the
        // top bit clear, a failed one wraps and sets it.
        q_bit      = ~prem_diff[WIDTH];
        prem_d     = q_bit ? prem_diff[WIDTH-1:0] : prem_shift[WIDTH-1:0];
        quo_d      = {quo_q[WIDTH-2:0], q_bit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            prem_q  <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            // No iterations needed; publish the fixed
                            // divide-by-zero answer directly.
                            res_q   <= '1;
                            rem_q   <= dividend;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            dvd_q   <= dividend;
                            dsr_q   <= divisor;
                            prem_q  <= '0;
                            quo_q   <= '0;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end

                RUN: begin
                    prem_q <= prem_d;
                    quo_q  <= quo_d;
                    dvd_q  <= {dvd_q[WIDTH-2:0], 1'b0};
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        res_q   <= quo_d;
                        rem_q   <= prem_d;
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    // start is deliberately not looked at here.
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign div_done    = done_q;
    assign div_result  = res_q;
    assign div_rem     = rem_q;
    assign div_by_zero = dbz_q;

endmodule
